// File: rtl/divsqrt_iter_ctrl.sv
// divsqrt_iter_ctrl: sequencing controller for the iterative radix-2
// carry-save divide/sqrt loop. Issues the datapath load strobe, enables one
// residual iteration per cycle for a programmable count, terminates early on a
// zero carry-save residual, and holds Done until downstream accepts.
module divsqrt_iter_ctrl #(
   parameter int WIDTH     = 16,
   parameter int MAXITER   = 12,
   parameter int CW        = $clog2(MAXITER + 1),
   parameter int EARLYTERM = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Flush,
   input  logic             Stall,
   input  logic             SpecialCase,
   input  logic [CW-1:0]    NumIter,
   input  logic [WIDTH-1:0] WS,
   input  logic [WIDTH-1:0] WC,
   output logic             Busy,
   output logic             Load,
   output logic             IterEn,
   output logic             Done,
   output logic             ResZero,
   output logic             EarlyTerm,
   output logic [CW-1:0]    IterCount
);

   localparam logic [CW-1:0] MAX_N = CW'(MAXITER);
   localparam logic [CW-1:0] ONE_N = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FINAL,
      DONE
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   rem, rem_nxt;
   logic [CW-1:0]   iter_cnt, iter_cnt_nxt;
   logic            res_zero, res_zero_nxt;
   logic            early_term, early_term_nxt;
   logic            load_c;
   logic            iter_en_c;
   logic [CW-1:0]   n_eff;
   logic [WIDTH-1:0] sum_bits;
   logic [WIDTH-1:0] carry_sh;
   logic            rz;

   // WS+WC == 0 (mod 2^WIDTH) without a carry-propagate adder: the sum is zero
   // exactly when the half-sum equals the generated/propagated carries shifted up.
   assign sum_bits = WS ^ WC;
   assign carry_sh = (WS | WC) << 1;
   assign rz       = (sum_bits == carry_sh);

   // Clamp requested iteration count into 1..MAXITER.
   always_comb begin
      n_eff = NumIter;
      if (NumIter == '0) begin
         n_eff = ONE_N;
      end else if (NumIter > MAX_N) begin
         n_eff = MAX_N;
      end
   end

   // Next-state and strobe decode; Flush overrides every state and suppresses strobes.
   always_comb begin
      state_nxt      = state;
      rem_nxt        = rem;
      iter_cnt_nxt   = iter_cnt;
      res_zero_nxt   = res_zero;
      early_term_nxt = early_term;
      load_c         = 1'b0;
      iter_en_c      = 1'b0;

      if (Flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  iter_cnt_nxt   = '0;
                  res_zero_nxt   = 1'b0;
                  early_term_nxt = 1'b0;
                  if (SpecialCase) begin
                     state_nxt = DONE;
                  end else begin
                     load_c    = 1'b1;
                     rem_nxt   = n_eff;
                     state_nxt = BUSY;
                  end
               end
            end
            BUSY: begin
               if ((EARLYTERM != 0) && rz) begin
                  res_zero_nxt   = 1'b1;
                  early_term_nxt = (rem != '0);
                  state_nxt      = DONE;
               end else begin
                  iter_en_c    = 1'b1;
                  iter_cnt_nxt = iter_cnt + ONE_N;
                  rem_nxt      = rem - ONE_N;
                  if (rem == ONE_N) begin
                     state_nxt = FINAL;
                  end
               end
            end
            FINAL: begin
               res_zero_nxt = rz;
               state_nxt    = DONE;
            end
            DONE: begin
               if (!Stall) begin
                  state_nxt = IDLE;
               end
            end
         endcase
      end
   end

   // State, down-counter and registered status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rem        <= '0;
         iter_cnt   <= '0;
         res_zero   <= 1'b0;
         early_term <= 1'b0;
      end else begin
         state      <= state_nxt;
         rem        <= rem_nxt;
         iter_cnt   <= iter_cnt_nxt;
         res_zero   <= res_zero_nxt;
         early_term <= early_term_nxt;
      end
   end

   // Load is decoded from live inputs in IDLE, so it is masked while reset is held.
   assign Load      = load_c & ~reset;
   assign IterEn    = iter_en_c;
   assign Busy      = (state != IDLE);
   assign Done      = (state == DONE);
   assign ResZero   = res_zero;
   assign EarlyTerm = early_term;
   assign IterCount = iter_cnt;

endmodule

// File: tb/tb_divsqrt_iter_ctrl.sv
// tb_divsqrt_iter_ctrl: directed bench for divsqrt_iter_ctrl. Two instances share
// stimulus: one with early termination enabled, one that always runs the full count.
module tb_divsqrt_iter_ctrl;

   localparam int WIDTH   = 16;
   localparam int MAXITER = 12;
   localparam int CW      = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             Start = 1'b0;
   logic             Flush = 1'b0;
   logic             Stall = 1'b0;
   logic             SpecialCase = 1'b0;
   logic [CW-1:0]    NumIter = '0;
   logic [WIDTH-1:0] WS = 16'h0001;
   logic [WIDTH-1:0] WC = 16'h0000;

   logic [1:0]       busy, load, iter_en, done, res_zero, early_term;
   logic [CW-1:0]    cnt_a, cnt_b;

   int n_pass   = 0;
   int n_checks = 0;

   int            iters[2], first_it[2], last_it[2], done_cyc[2], loads[2], excl[2];
   logic [CW-1:0] cnt_at_done[2];
   logic          rz_at_done[2], et_at_done[2];

   divsqrt_iter_ctrl #(.WIDTH(WIDTH), .MAXITER(MAXITER), .CW(CW), .EARLYTERM(1)) u_dut (
      .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Stall(Stall),
      .SpecialCase(SpecialCase), .NumIter(NumIter), .WS(WS), .WC(WC),
      .Busy(busy[0]), .Load(load[0]), .IterEn(iter_en[0]), .Done(done[0]),
      .ResZero(res_zero[0]), .EarlyTerm(early_term[0]), .IterCount(cnt_a)
   );

   divsqrt_iter_ctrl #(.WIDTH(WIDTH), .MAXITER(MAXITER), .CW(CW), .EARLYTERM(0)) u_dut_full (
      .clk(clk), .reset(reset), .Start(Start), .Flush(Flush), .Stall(Stall),
      .SpecialCase(SpecialCase), .NumIter(NumIter), .WS(WS), .WC(WC),
      .Busy(busy[1]), .Load(load[1]), .IterEn(iter_en[1]), .Done(done[1]),
      .ResZero(res_zero[1]), .EarlyTerm(early_term[1]), .IterCount(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_res(input logic zero);
      WS = zero ? 16'h8001 : 16'h0001;
      WC = zero ? 16'h7FFF : 16'h0000;
   endtask

   function automatic logic [CW-1:0] cnt_of(input int i);
      return (i == 0) ? cnt_a : cnt_b;
   endfunction

   task automatic record(input int c);
      for (int i = 0; i < 2; i++) begin
         if (iter_en[i]) begin
            iters[i]++;
            if (first_it[i] < 0) first_it[i] = c;
            last_it[i] = c;
         end
         if (load[i]) loads[i]++;
         if (int'(load[i]) + int'(iter_en[i]) + int'(done[i]) > 1) excl[i]++;
         if (done[i] && done_cyc[i] < 0) begin
            done_cyc[i]    = c;
            cnt_at_done[i] = cnt_of(i);
            rz_at_done[i]  = res_zero[i];
            et_at_done[i]  = early_term[i];
         end
      end
   endtask

   // Cycle 0 carries Start; the residual reads as zero from cycle rz_cyc onwards.
   task automatic run_op(input logic [CW-1:0] niter, input int rz_cyc);
      for (int i = 0; i < 2; i++) begin
         iters[i] = 0; first_it[i] = -1; last_it[i] = -1;
         done_cyc[i] = -1; loads[i] = 0; excl[i] = 0;
         cnt_at_done[i] = '1; rz_at_done[i] = 1'bx; et_at_done[i] = 1'bx;
      end
      next_cycle();
      Start = 1'b1;
      NumIter = niter;
      set_res(rz_cyc <= 0);
      #1;
      record(0);
      for (int c = 1; c < 20; c++) begin
         next_cycle();
         Start = 1'b0;
         set_res(c >= rz_cyc);
         #1;
         record(c);
      end
   endtask

   task automatic check_op(input string tag, input int i, input int e_iters, input int e_first,
                           input int e_last, input int e_done, input int e_cnt,
                           input logic e_rz, input logic e_et);
      check($sformatf("%s loads", tag), loads[i], 1);
      check($sformatf("%s iters", tag), iters[i], e_iters);
      check($sformatf("%s first_iter", tag), first_it[i], e_first);
      check($sformatf("%s last_iter", tag), last_it[i], e_last);
      check($sformatf("%s done_cycle", tag), done_cyc[i], e_done);
      check($sformatf("%s itercount", tag), 32'(cnt_at_done[i]), e_cnt);
      check($sformatf("%s reszero", tag), 32'(rz_at_done[i]), 32'(e_rz));
      check($sformatf("%s earlyterm", tag), 32'(et_at_done[i]), 32'(e_et));
      check($sformatf("%s exclusive", tag), excl[i], 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Power-on reset values.
      #1;
      check("por busy", 32'(busy[0]), 0);
      check("por done", 32'(done[0]), 0);
      check("por itercount", 32'(cnt_a), 0);
      check("por reszero", 32'(res_zero[0]), 0);
      check("por earlyterm", 32'(early_term[0]), 0);
      next_cycle();
      next_cycle();
      reset = 1'b0;

      // Reset asserted mid-BUSY on a NumIter=5 op.
      next_cycle();
      Start = 1'b1; NumIter = 4'd5; set_res(1'b0);
      #1;
      check("rst load c0", 32'(load[0]), 1);
      next_cycle(); Start = 1'b0; #1;
      next_cycle(); #1;
      next_cycle();
      #1;
      check("rst itercount before", 32'(cnt_a), 2);
      reset = 1'b1; Start = 1'b1;
      #1;
      check("rst busy", 32'(busy[0]), 0);
      check("rst load", 32'(load[0]), 0);
      check("rst iteren", 32'(iter_en[0]), 0);
      check("rst done", 32'(done[0]), 0);
      check("rst itercount", 32'(cnt_a), 0);
      next_cycle();
      #1;
      check("rst held load", 32'(load[0]), 0);
      reset = 1'b0; Start = 1'b0;
      next_cycle();

      // Full run, residual never zero.
      run_op(4'd4, 99);
      check_op("n4", 0, 4, 1, 4, 6, 4, 1'b0, 1'b0);

      // Residual sum wraps to zero in cycle 3.
      run_op(4'd6, 3);
      check_op("early", 0, 2, 1, 2, 4, 2, 1'b1, 1'b1);
      check_op("noearly", 1, 6, 1, 6, 8, 6, 1'b1, 1'b0);

      // Special operands: no iterations, Done held under Stall, Start in DONE ignored.
      next_cycle();
      Start = 1'b1; SpecialCase = 1'b1; NumIter = 4'd4; set_res(1'b0);
      #1;
      check("spec load c0", 32'(load[0]), 0);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         SpecialCase = 1'b0;
         Start = 1'b1;
         Stall = (c <= 3);
         #1;
         check($sformatf("spec done c%0d", c), 32'(done[0]), 1);
         check($sformatf("spec load c%0d", c), 32'(load[0]), 0);
         check($sformatf("spec itercount c%0d", c), 32'(cnt_a), 0);
         check($sformatf("spec reszero c%0d", c), 32'(res_zero[0]), 0);
      end
      next_cycle();
      Start = 1'b0; Stall = 1'b0;
      #1;
      check("spec idle c5 done", 32'(done[0]), 0);
      check("spec idle c5 busy", 32'(busy[0]), 0);
      next_cycle();
      #1;
      check("spec idle c6 busy", 32'(busy[0]), 0);

      // Count clamping at both ends.
      run_op(4'd0, 99);
      check_op("n0", 0, 1, 1, 1, 3, 1, 1'b0, 1'b0);
      run_op(4'd15, 99);
      check_op("n15", 0, 12, 1, 12, 14, 12, 1'b0, 1'b0);

      // Flush in cycle 2 of a NumIter=5 op.
      next_cycle();
      Start = 1'b1; NumIter = 4'd5; set_res(1'b0);
      #1;
      check("flush load c0", 32'(load[0]), 1);
      next_cycle(); Start = 1'b0; #1;
      check("flush iteren c1", 32'(iter_en[0]), 1);
      next_cycle(); Flush = 1'b1; #1;
      check("flush iteren c2", 32'(iter_en[0]), 0);
      check("flush done c2", 32'(done[0]), 0);
      next_cycle(); Flush = 1'b0; #1;
      check("flush busy c3", 32'(busy[0]), 0);
      check("flush itercount c3", 32'(cnt_a), 1);
      begin
         int done_seen;
         done_seen = 0;
         for (int c = 4; c < 12; c++) begin
            next_cycle(); #1;
            if (done[0] || iter_en[0]) done_seen++;
         end
         check("flush no activity", done_seen, 0);
      end

      // Flush coincident with Start in IDLE.
      next_cycle();
      Start = 1'b1; Flush = 1'b1; NumIter = 4'd3;
      #1;
      check("flushstart load", 32'(load[0]), 0);
      next_cycle();
      Start = 1'b0; Flush = 1'b0;
      #1;
      check("flushstart busy", 32'(busy[0]), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/divsqrt_iter_ctrl.md
# divsqrt_iter_ctrl

Sequencing controller for the iterative radix-2 carry-save divide/sqrt loop in the FPU. It accepts an operation request and pulses the datapath load. It then enables one residual iteration per cycle for a programmable count and terminates early when the carry-save residual sums to zero. Finally it reports a registered residual-zero (exact result) flag and holds Done until the downstream stage accepts.

## Interface
Parameters:
- WIDTH, 16, width of the carry-save residual words.
- MAXITER, 12, maximum iterations per operation.
- CW, $clog2(MAXITER+1), width of iteration count fields.
- EARLYTERM, 1, 1 enables early termination on zero residual; 0 always runs the full count.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  operation request; sampled only in IDLE.
- Flush  in  1  abort; overrides everything, next state IDLE.
- Stall  in  1  downstream not ready; holds DONE.
- SpecialCase  in  1  operands are special (NaN/Inf/zero); skip iterations.
- NumIter  in  CW  iterations for this op; sampled with Start.
- WS, WC  in  WIDTH  carry-save residual sum and carry words from the datapath.
- Busy  out  1  state != IDLE.
- Load  out  1  one-cycle datapath initialize strobe.
- IterEn  out  1  advance datapath one iteration this cycle.
- Done  out  1  result valid (DONE state).
- ResZero  out  1  registered: final residual == 0.
- EarlyTerm  out  1  registered: op ended before NumIter iterations.
- IterCount  out  CW  iterations performed for current/last op.

## Operation
- Residual zero detect (combinational): RZ = ((WS ^ WC) == {(WS | WC)[WIDTH-2:0], 1'b0}). This is WS+WC == 0 modulo 2^WIDTH with no carry-propagate adder, and carry-out is discarded.
- Effective count N = 1 if NumIter==0, MAXITER if NumIter>MAXITER, else NumIter. It is latched into an internal down-counter Rem.
- FSM states: IDLE, BUSY, FINAL, DONE.
- IDLE: Start & ~Flush & ~SpecialCase -> Load=1 (combinational), Rem<=N, IterCount<=0, ResZero<=0, EarlyTerm<=0, next BUSY.
- IDLE: Start & ~Flush & SpecialCase -> no Load, IterCount<=0, ResZero<=0, EarlyTerm<=0, next DONE.
- BUSY with EARLYTERM & RZ -> IterEn=0, ResZero<=1, EarlyTerm<=(Rem!=0), next DONE.
- BUSY otherwise -> IterEn=1, IterCount+=1, Rem-=1. If Rem==1, next FINAL, else stay.
- FINAL: IterEn=0; ResZero<=RZ (evaluated on residual after last iteration); next DONE.
- DONE: Done=1; Stall holds DONE with all outputs stable; ~Stall -> IDLE. Start in DONE is ignored (no queueing).
- Flush in any state -> IDLE at next edge. No Load or IterEn is asserted in a cycle with Flush=1. IterCount/ResZero/EarlyTerm hold their values.
- Reset (asynchronous, any state including mid-iteration): state IDLE, Rem=0, IterCount=0, ResZero=0, EarlyTerm=0. All outputs are 0 while reset is high.
- Load, IterEn, and Done are mutually exclusive in every cycle.

## Timing
- Start accepted in cycle 0 (Load=1). IterEn is high in cycles 1..N. FINAL is cycle N+1, and Done is first high in cycle N+2 (full-run latency N+2).
- RZ is first evaluated in cycle 1, on the just-loaded residual. Early termination at BUSY cycle k gives Done in cycle k+1, with IterCount=k-1.
- SpecialCase: Done in cycle 1, IterCount=0, ResZero=0.
- Back-to-back: Done with ~Stall in cycle t puts the FSM in IDLE at t+1. The earliest next Load is t+1, so throughput is one op per N+3 cycles.
- Outputs ResZero, EarlyTerm, and IterCount are registered and valid whenever Done=1.

## Test plan
- Reset mid-BUSY (NumIter=5, assert reset in cycle 3) -> IDLE immediately; Busy=Load=IterEn=Done=0, IterCount=0 while reset high; next Start runs normally.
- NumIter=4, WS=16'h0001, WC=16'h0000 held -> Load cycle 0, IterEn cycles 1-4, Done cycle 6, IterCount=4, ResZero=0, EarlyTerm=0.
- NumIter=6, residual becomes WS=16'h8001, WC=16'h7FFF (sum wraps to 0) in cycle 3 -> IterEn cycles 1-2 only, Done cycle 4, IterCount=2, ResZero=1, EarlyTerm=1; repeat with EARLYTERM=0 -> full 6 iterations, Done cycle 8.
- NumIter=0 and NumIter=15 (MAXITER=12) -> exactly 1 and 12 IterEn pulses respectively.
- SpecialCase=1 with Start -> Load never asserted, Done cycle 1, IterCount=0; hold Stall=1 for 3 cycles -> Done stays high 4 cycles, then IDLE; Start during DONE ignored.
- Flush in cycle 2 of NumIter=5 run -> IDLE at cycle 3, no Done, no IterEn in cycle 2; Flush coincident with Start in IDLE -> no Load, stays IDLE.
